alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Command-driven controller wrapping one ALU instance and an 8-entry register file.
//  Accepts one instruction per valid/ready handshake and reads operands from the register file.
//  Sequences the ALU (single-cycle ops, or multi-cycle shift-add MUL), writes back, and returns result+flags on a valid/ready response channel.
//  Sits between the top-level command source (test FSM / host) and the ALU datapath.
// PARAMETERS
//  nbit   16   datapath width; also the ALU width and the MUL iteration count
// PORTS
//  clk        in   1     single clock, rising edge
//  rst_n      in   1     asynchronous, active-low reset
//  cmd_valid  in   1     command present
//  cmd_ready  out  1     sequencer can accept (IDLE only)
//  cmd_op     in   4     0-7 ALU Sel; 8 LDI; 9 MUL; 10 NOP; 11-15 illegal
//  cmd_rd     in   3     destination register
//  cmd_ra     in   3     operand A register
//  cmd_rb     in   3     operand B register
//  cmd_imm    in   nbit  LDI immediate
//  rsp_valid  out  1     response present
//  rsp_ready  in   1     response consumed
//  rsp_data   out  nbit  result written to rd (0 for NOP/illegal)
//  rsp_flags  out  4     {V,C,N,Z} of this op
//  rsp_err    out  1     illegal opcode
//  busy       out  1     state != IDLE
//  dbg_addr   in   3     debug read address
//  dbg_data   out  nbit  combinational read of regfile[dbg_addr]
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, all regs r0-r7=0, cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_flags=0, rsp_err=0, busy=0.
//  Accept: cmd_valid&&cmd_ready at edge T0 -> latch op/rd/imm and regfile[ra], regfile[rb] (ra==rd safe).
//  FSM states: IDLE, EXEC, MUL, RESP.
//   IDLE: cmd_ready=1; on accept -> MUL if op==9, else EXEC.
//   EXEC (1 cycle): ALU A=opA, B=opB, Sel=op[2:0], shin=1. Writeback at end of cycle: ALU ops and LDI only; NOP/illegal write nothing. -> RESP.
//   MUL (exactly nbit cycles): acc=0, mcand=opA, mplier=opB at entry.
//    Each cycle: if mplier[0], acc<=ALU(acc+mcand, Sel=000); mcand<<=1; mplier>>=1.
//    Writeback of acc (low nbit of product) at end of last cycle -> RESP.
//   RESP: rsp_valid=1; data/flags/err stable until rsp_ready; on handshake -> IDLE.
//  Latency: ALU/LDI/NOP/illegal rsp_valid from T2; MUL from T(nbit+1). No accept in the handshake cycle.
//  Flags (computed locally; ALU flag outputs used only for C):
//   Z = result==0; N = result[nbit-1].
//   ADD: C = ALU carry; V = signed overflow (opA/opB same sign, result differs).
//   SUB: C = ALU borrow bit; V = signed overflow of A-B.
//   AND/OR (logical, result 0/1), XOR, NOT, SHL, SHR, LDI, MUL: C=V=0.
//   NOP, illegal: flags=0, rsp_err=1 only for illegal.
//  cmd_ready=0 in every state except IDLE; cmd_valid outside IDLE is ignored, never queued.
//  Regfile is already updated while RESP stalls; dbg_data reflects it.
//  Reset mid-operation: in-flight command discarded, no writeback, regfile cleared.
// STRUCTURE
//  Shared package alu_seq_pkg: opcode constants (OP_ADD..OP_SHR=0-7, OP_LDI=8, OP_MUL=9, OP_NOP=10), FSM state encoding, flag bit indices.
//  Sub-module alu_regfile: 8 x nbit, 1 write port, 3 comb read ports (A, B, dbg), async reset to 0.
//  ALU instantiated once, parameter nbit passed through; FSM, operand/acc regs, flag logic live in the top.
// TESTING (nbit=16)
//  LDI r1=0x7FFF, LDI r2=0x0001, ADD r3,r1,r2 -> rsp_data=0x8000, flags{V,C,N,Z}=1010, rsp_valid at T2.
//  LDI r1=0xFFFF, ADD r3,r1,r2(=1) -> 0x0000, flags=0101; SUB r4,r2,r1 (1-0xFFFF) -> 0x0002, C=1.
//  MUL: r1=0x0012, r2=0x0034 -> rsp_data=0x03A8 exactly 17 cycles after accept; then 0xFFFF*0xFFFF -> 0x0001.
//   cmd_valid pulsed during busy -> cmd_ready=0, command dropped.
//  rsp_ready held 0 for 10 cycles -> rsp_* stable, dbg_addr=rd shows new value; op=0xF -> rsp_err=1, no regfile change.
//  rst_n low at MUL iteration 5 -> all outputs at reset values immediately; after release cmd_ready=1, rd=0.
//  SHL/SHR r1=0x8001 -> 0x0002 / 0x4000, C=V=0; AND 0x00F0,0 -> 0x0000, Z=1.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU op sequencer: opcodes, FSM states and the
// response flag layout.
package alu_seq_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_LDI = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd9;
    localparam logic [3:0] OP_NOP = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_MUL,
        ST_RESP
    } state_t;

    // Field order gives the {V,C,N,Z} bit layout of rsp_flags.
    typedef struct packed {
        logic v;
        logic c;
        logic n;
        logic z;
    } flags_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU: eight operations selected by i_sel, carry/borrow on o_c.
module alu
    import alu_seq_pkg::*;
#(
    parameter int nbit = 16
) (
    input  logic [nbit-1:0] i_a,
    input  logic [nbit-1:0] i_b,
    input  logic [2:0]      i_sel,
    input  logic            i_shin,
    output logic [nbit-1:0] o_y,
    output logic            o_c
);

    logic [nbit:0] w_wide;

    // i_shin is the shift distance (0 or 1); vacated bits are zero-filled.
    always_comb begin
        w_wide = '0;
        case (i_sel)
            OP_ADD[2:0]: w_wide = {1'b0, i_a} + {1'b0, i_b};
            OP_SUB[2:0]: w_wide = {1'b0, i_a} - {1'b0, i_b};
            OP_AND[2:0]: w_wide[0] = (|i_a) && (|i_b);
            OP_OR[2:0]:  w_wide[0] = (|i_a) || (|i_b);
            OP_XOR[2:0]: w_wide[nbit-1:0] = i_a ^ i_b;
            OP_NOT[2:0]: w_wide[nbit-1:0] = ~i_a;
            OP_SHL[2:0]: w_wide[nbit-1:0] = i_a << i_shin;
            OP_SHR[2:0]: w_wide[nbit-1:0] = i_a >> i_shin;
            default:     w_wide = '0;
        endcase
    end

    assign o_y = w_wide[nbit-1:0];
    assign o_c = w_wide[nbit];

endmodule

// File: rtl/alu_regfile.sv
// 8 x nbit register file: one write port, three combinational read ports,
// asynchronous clear.
module alu_regfile #(
    parameter int nbit = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_we,
    input  logic [2:0]      i_waddr,
    input  logic [nbit-1:0] i_wdata,
    input  logic [2:0]      i_raddr_a,
    input  logic [2:0]      i_raddr_b,
    input  logic [2:0]      i_raddr_dbg,
    output logic [nbit-1:0] o_rdata_a,
    output logic [nbit-1:0] o_rdata_b,
    output logic [nbit-1:0] o_rdata_dbg
);

    logic [nbit-1:0] r_mem [8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 8; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a   = r_mem[i_raddr_a];
    assign o_rdata_b   = r_mem[i_raddr_b];
    assign o_rdata_dbg = r_mem[i_raddr_dbg];

endmodule

// File: rtl/alu_op_sequencer.sv
// Command-driven sequencer around one ALU and an 8-entry register file:
// single-cycle ops, shift-add MUL, writeback and a valid/ready response.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int nbit = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [3:0]      cmd_op,
    input  logic [2:0]      cmd_rd,
    input  logic [2:0]      cmd_ra,
    input  logic [2:0]      cmd_rb,
    input  logic [nbit-1:0] cmd_imm,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [nbit-1:0] rsp_data,
    output logic [3:0]      rsp_flags,
    output logic            rsp_err,
    output logic            busy,
    input  logic [2:0]      dbg_addr,
    output logic [nbit-1:0] dbg_data
);

    localparam int unsigned CW = $clog2(nbit) + 1;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [3:0]      r_op;
    logic [2:0]      r_rd;
    logic [nbit-1:0] r_imm;
    logic [nbit-1:0] r_a;
    logic [nbit-1:0] r_b;
    logic [nbit-1:0] r_acc;
    logic [CW-1:0]   r_cnt;
    logic [nbit-1:0] r_rsp_data;
    flags_t          r_rsp_flags;
    logic            r_rsp_err;

    logic [nbit-1:0] w_rd_a;
    logic [nbit-1:0] w_rd_b;
    logic [nbit-1:0] w_alu_a;
    logic [nbit-1:0] w_alu_b;
    logic [2:0]      w_alu_sel;
    logic [nbit-1:0] w_alu_y;
    logic            w_alu_c;
    logic [nbit-1:0] w_acc_nxt;
    logic            w_accept;
    logic            w_mul_last;
    logic [nbit-1:0] w_res;
    flags_t          w_flags;
    logic            w_err;
    logic            w_res_ok;
    logic            w_c;
    logic            w_v;
    logic            w_wb_en;

    assign w_accept   = cmd_valid && (r_state == ST_IDLE);
    assign w_mul_last = (r_state == ST_MUL) && (r_cnt == CW'(nbit - 1));

    alu_regfile #(.nbit(nbit)) u_regfile (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_we        (w_wb_en),
        .i_waddr     (r_rd),
        .i_wdata     (w_res),
        .i_raddr_a   (cmd_ra),
        .i_raddr_b   (cmd_rb),
        .i_raddr_dbg (dbg_addr),
        .o_rdata_a   (w_rd_a),
        .o_rdata_b   (w_rd_b),
        .o_rdata_dbg (dbg_data)
    );

    // During MUL the ALU adds the multiplicand (held in r_a) to the accumulator.
    always_comb begin
        w_alu_a   = r_a;
        w_alu_b   = r_b;
        w_alu_sel = r_op[2:0];
        if (r_state == ST_MUL) begin
            w_alu_a   = r_acc;
            w_alu_b   = r_a;
            w_alu_sel = OP_ADD[2:0];
        end
    end

    alu #(.nbit(nbit)) u_alu (
        .i_a    (w_alu_a),
        .i_b    (w_alu_b),
        .i_sel  (w_alu_sel),
        .i_shin (1'b1),
        .o_y    (w_alu_y),
        .o_c    (w_alu_c)
    );

    assign w_acc_nxt = r_b[0] ? w_alu_y : r_acc;

    always_comb begin
        w_res    = '0;
        w_err    = 1'b0;
        w_res_ok = 1'b0;
        w_c      = 1'b0;
        w_v      = 1'b0;
        if (r_state == ST_MUL) begin
            w_res    = w_acc_nxt;
            w_res_ok = 1'b1;
        end else begin
            case (r_op)
                OP_ADD: begin
                    w_res    = w_alu_y;
                    w_res_ok = 1'b1;
                    w_c      = w_alu_c;
                    w_v      = (r_a[nbit-1] == r_b[nbit-1]) && (w_alu_y[nbit-1] != r_a[nbit-1]);
                end
                OP_SUB: begin
                    w_res    = w_alu_y;
                    w_res_ok = 1'b1;
                    w_c      = w_alu_c;
                    w_v      = (r_a[nbit-1] != r_b[nbit-1]) && (w_alu_y[nbit-1] != r_a[nbit-1]);
                end
                OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR: begin
                    w_res    = w_alu_y;
                    w_res_ok = 1'b1;
                end
                OP_LDI: begin
                    w_res    = r_imm;
                    w_res_ok = 1'b1;
                end
                OP_NOP, OP_MUL: ;
                default: w_err = 1'b1;
            endcase
        end
        w_flags = '0;
        if (w_res_ok) begin
            w_flags.z = (w_res == '0);
            w_flags.n = w_res[nbit-1];
            w_flags.c = w_c;
            w_flags.v = w_v;
        end
    end

    assign w_wb_en = ((r_state == ST_EXEC) && w_res_ok) || w_mul_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        cmd_ready   = 1'b0;
        rsp_valid   = 1'b0;
        busy        = 1'b1;
        case (r_state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    w_state_nxt = (cmd_op == OP_MUL) ? ST_MUL : ST_EXEC;
                end
            end
            ST_EXEC: w_state_nxt = ST_RESP;
            ST_MUL: begin
                if (w_mul_last) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op        <= '0;
            r_rd        <= '0;
            r_imm       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_rsp_data  <= '0;
            r_rsp_flags <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op  <= cmd_op;
                        r_rd  <= cmd_rd;
                        r_imm <= cmd_imm;
                        r_a   <= w_rd_a;
                        r_b   <= w_rd_b;
                        r_acc <= '0;
                        r_cnt <= '0;
                    end
                end
                ST_EXEC: begin
                    r_rsp_data  <= w_res;
                    r_rsp_flags <= w_flags;
                    r_rsp_err   <= w_err;
                end
                ST_MUL: begin
                    r_acc <= w_acc_nxt;
                    r_a   <= r_a << 1;
                    r_b   <= r_b >> 1;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_mul_last) begin
                        r_rsp_data  <= w_res;
                        r_rsp_flags <= w_flags;
                        r_rsp_err   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_data  = r_rsp_data;
    assign rsp_flags = r_rsp_flags;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer (nbit=16): directed cases plus
// random commands against an arithmetic reference model of the register file.
module tb_alu_op_sequencer;

    localparam int NB      = 16;
    localparam int LAT_ONE = 1;   // edges after accept until rsp_valid (seen at T2)
    localparam int LAT_MUL = NB;  // rsp_valid seen at T(nbit+1)

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_op = '0;
    logic [2:0]  cmd_rd = '0;
    logic [2:0]  cmd_ra = '0;
    logic [2:0]  cmd_rb = '0;
    logic [15:0] cmd_imm = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_data;
    logic [3:0]  rsp_flags;
    logic        rsp_err;
    logic        busy;
    logic [2:0]  dbg_addr = '0;
    logic [15:0] dbg_data;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] m_regs [8];

    typedef struct {
        logic [3:0]  op;
        logic [2:0]  rd, ra, rb;
        logic [15:0] imm;
        logic [15:0] data;
        logic [3:0]  flags;
        int          lat;
    } dir_t;
    dir_t dir_tbl [17];

    alu_op_sequencer #(.nbit(NB)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_imm(cmd_imm),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_flags(rsp_flags), .rsp_err(rsp_err), .busy(busy),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    // Reference semantics from plain arithmetic; wr says whether rd is written.
    function automatic void ref_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                   input logic [15:0] imm, output logic [15:0] res,
                                   output logic [3:0] flags, output logic err, output logic wr);
        int sa, sb, sr;
        logic c, v;
        logic [31:0] prod;
        sa = int'($signed(a));
        sb = int'($signed(b));
        res = '0; c = 1'b0; v = 1'b0; err = 1'b0; wr = 1'b1;
        case (op)
            4'd0: begin res = a + b; c = (int'(a) + int'(b)) > 65535; sr = sa + sb; v = (sr > 32767) || (sr < -32768); end
            4'd1: begin res = a - b; c = a < b; sr = sa - sb; v = (sr > 32767) || (sr < -32768); end
            4'd2: res = {15'b0, (a != 0) && (b != 0)};
            4'd3: res = {15'b0, (a != 0) || (b != 0)};
            4'd4: res = a ^ b;
            4'd5: res = ~a;
            4'd6: res = a << 1;
            4'd7: res = a >> 1;
            4'd8: res = imm;
            4'd9: begin prod = 32'(a) * 32'(b); res = prod[15:0]; end
            4'd10: wr = 1'b0;
            default: begin wr = 1'b0; err = 1'b1; end
        endcase
        flags = wr ? {v, c, res[15], res == 16'h0} : 4'b0000;
    endfunction

    // Issue one command, wait (bounded) for the response, hold it for 'stall' cycles, consume it.
    task automatic do_cmd(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] ra,
                          input logic [2:0] rb, input logic [15:0] imm, input int stall,
                          output int lat, output logic [15:0] data, output logic [3:0] flags,
                          output logic err);
        @(negedge clk);
        cmd_op = op; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb; cmd_imm = imm; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1 lat++;
        end
        data = rsp_data; flags = rsp_flags; err = rsp_err;
        repeat (stall) @(posedge clk);
        @(negedge clk) rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    // do_cmd plus reference model; returns observed and expected responses.
    task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] ra,
                         input logic [2:0] rb, input logic [15:0] imm, output int lat,
                         output logic [20:0] got, output logic [20:0] exp);
        logic [15:0] er, d;
        logic [3:0]  ef, f;
        logic        ee, wr, e;
        ref_op(op, m_regs[ra], m_regs[rb], imm, er, ef, ee, wr);
        do_cmd(op, rd, ra, rb, imm, 0, lat, d, f, e);
        if (wr) m_regs[rd] = er;
        got = {d, f, e};
        exp = {er, ef, ee};
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({cmd_ready, busy, rsp_valid, rsp_data, rsp_flags, rsp_err} !== {1'b1, 1'b0, 1'b0, 21'h0}) begin
            n_errors++;
            $display("FAIL reset_outputs: got rdy=%b busy=%b vld=%b data=%h flags=%b err=%b, want 1 0 0 0000 0000 0",
                     cmd_ready, busy, rsp_valid, rsp_data, rsp_flags, rsp_err);
        end
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            m_regs[i] = '0;
            dbg_addr = 3'(i);
            #1;
            n_checks++;
            if (dbg_data !== 16'h0) begin
                n_errors++;
                $display("FAIL reset_reg r%0d: got %h, want 0000", i, dbg_data);
            end
        end
    endtask

    task automatic test_directed();
        int lat;
        logic [20:0] got, exp;
        dir_tbl[0]  = '{4'd8, 3'd1, 3'd0, 3'd0, 16'h7FFF, 16'h7FFF, 4'b0000, LAT_ONE};
        dir_tbl[1]  = '{4'd8, 3'd2, 3'd0, 3'd0, 16'h0001, 16'h0001, 4'b0000, LAT_ONE};
        dir_tbl[2]  = '{4'd0, 3'd3, 3'd1, 3'd2, 16'h0000, 16'h8000, 4'b1010, LAT_ONE};
        dir_tbl[3]  = '{4'd8, 3'd1, 3'd0, 3'd0, 16'hFFFF, 16'hFFFF, 4'b0010, LAT_ONE};
        dir_tbl[4]  = '{4'd0, 3'd3, 3'd1, 3'd2, 16'h0000, 16'h0000, 4'b0101, LAT_ONE};
        dir_tbl[5]  = '{4'd1, 3'd4, 3'd2, 3'd1, 16'h0000, 16'h0002, 4'b0100, LAT_ONE};
        dir_tbl[6]  = '{4'd8, 3'd1, 3'd0, 3'd0, 16'h0012, 16'h0012, 4'b0000, LAT_ONE};
        dir_tbl[7]  = '{4'd8, 3'd2, 3'd0, 3'd0, 16'h0034, 16'h0034, 4'b0000, LAT_ONE};
        dir_tbl[8]  = '{4'd9, 3'd5, 3'd1, 3'd2, 16'h0000, 16'h03A8, 4'b0000, LAT_MUL};
        dir_tbl[9]  = '{4'd8, 3'd1, 3'd0, 3'd0, 16'hFFFF, 16'hFFFF, 4'b0010, LAT_ONE};
        dir_tbl[10] = '{4'd9, 3'd6, 3'd1, 3'd1, 16'h0000, 16'h0001, 4'b0000, LAT_MUL};
        dir_tbl[11] = '{4'd8, 3'd1, 3'd0, 3'd0, 16'h8001, 16'h8001, 4'b0010, LAT_ONE};
        dir_tbl[12] = '{4'd6, 3'd3, 3'd1, 3'd0, 16'h0000, 16'h0002, 4'b0000, LAT_ONE};
        dir_tbl[13] = '{4'd7, 3'd3, 3'd1, 3'd0, 16'h0000, 16'h4000, 4'b0000, LAT_ONE};
        dir_tbl[14] = '{4'd8, 3'd0, 3'd0, 3'd0, 16'h0000, 16'h0000, 4'b0001, LAT_ONE};
        dir_tbl[15] = '{4'd8, 3'd7, 3'd0, 3'd0, 16'h00F0, 16'h00F0, 4'b0000, LAT_ONE};
        dir_tbl[16] = '{4'd2, 3'd3, 3'd7, 3'd0, 16'h0000, 16'h0000, 4'b0001, LAT_ONE};
        for (int i = 0; i < 17; i++) begin
            issue(dir_tbl[i].op, dir_tbl[i].rd, dir_tbl[i].ra, dir_tbl[i].rb, dir_tbl[i].imm, lat, got, exp);
            n_checks++;
            if (got !== {dir_tbl[i].data, dir_tbl[i].flags, 1'b0}) begin
                n_errors++;
                $display("FAIL directed[%0d] op=%0d: got data=%h flags=%b err=%b, want data=%h flags=%b err=0",
                         i, dir_tbl[i].op, got[20:5], got[4:1], got[0], dir_tbl[i].data, dir_tbl[i].flags);
            end
            n_checks++;
            if (lat !== dir_tbl[i].lat) begin
                n_errors++;
                $display("FAIL directed_latency[%0d]: got %0d, want %0d", i, lat, dir_tbl[i].lat);
            end
        end
    endtask

    task automatic test_busy_drop();
        logic [15:0] er;
        logic [3:0]  ef;
        logic        ee, wr;
        int          lat;
        ref_op(4'd9, m_regs[1], m_regs[2], 16'h0, er, ef, ee, wr);
        @(negedge clk);
        cmd_op = 4'd9; cmd_rd = 3'd5; cmd_ra = 3'd1; cmd_rb = 3'd2; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        m_regs[5] = er;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cmd_op = 4'd8; cmd_rd = 3'd5; cmd_imm = 16'hBEEF; cmd_valid = 1'b1;
            #1;
            n_checks++;
            if ({cmd_ready, busy} !== 2'b01) begin
                n_errors++;
                $display("FAIL busy_ready[%0d]: got rdy=%b busy=%b, want 0 1", i, cmd_ready, busy);
            end
        end
        @(negedge clk) cmd_valid = 1'b0;
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1 lat++;
        end
        n_checks++;
        if ({rsp_data, rsp_flags, rsp_err} !== {er, ef, ee}) begin
            n_errors++;
            $display("FAIL busy_mul_rsp: got %h/%b/%b, want %h/%b/%b", rsp_data, rsp_flags, rsp_err, er, ef, ee);
        end
        @(negedge clk) rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 dbg_addr = 3'd5;
        #1;
        n_checks++;
        if ({rsp_valid, busy, dbg_data} !== {2'b00, er}) begin
            n_errors++;
            $display("FAIL busy_dropped: got vld=%b busy=%b r5=%h, want 0 0 %h", rsp_valid, busy, dbg_data, er);
        end
    endtask

    task automatic test_stall_illegal();
        logic [15:0] er;
        logic [3:0]  ef;
        logic        ee, wr;
        int          lat;
        logic [20:0] got, exp;
        ref_op(4'd0, m_regs[4], m_regs[5], 16'h0, er, ef, ee, wr);
        @(negedge clk);
        cmd_op = 4'd0; cmd_rd = 3'd6; cmd_ra = 3'd4; cmd_rb = 3'd5; cmd_valid = 1'b1;
        dbg_addr = 3'd6;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        m_regs[6] = er;
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1 lat++;
        end
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if ({rsp_valid, rsp_data, rsp_flags, rsp_err, dbg_data} !== {1'b1, er, ef, ee, er}) begin
                n_errors++;
                $display("FAIL stall_hold[%0d]: got vld=%b %h/%b/%b dbg=%h, want 1 %h/%b/%b dbg=%h",
                         i, rsp_valid, rsp_data, rsp_flags, rsp_err, dbg_data, er, ef, ee, er);
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk) rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        issue(4'hF, 3'd6, 3'd1, 3'd2, 16'h1234, lat, got, exp);
        n_checks++;
        if (got !== {16'h0, 4'b0000, 1'b1}) begin
            n_errors++;
            $display("FAIL illegal_rsp: got %h, want %h", got, {16'h0, 4'b0000, 1'b1});
        end
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            n_checks++;
            if (dbg_data !== m_regs[i]) begin
                n_errors++;
                $display("FAIL illegal_reg r%0d: got %h, want %h", i, dbg_data, m_regs[i]);
            end
        end
    endtask

    task automatic test_random();
        int lat;
        logic [20:0] got, exp;
        logic [3:0]  op;
        for (int i = 0; i < 8; i++) begin
            issue(4'd8, 3'(i), 3'd0, 3'd0, 16'($urandom), lat, got, exp);
        end
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            issue(op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  16'($urandom), lat, got, exp);
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL random[%0d] op=%0d: got %h/%b/%b, want %h/%b/%b",
                         i, op, got[20:5], got[4:1], got[0], exp[20:5], exp[4:1], exp[0]);
            end
            n_checks++;
            if (lat !== ((op == 4'd9) ? LAT_MUL : LAT_ONE)) begin
                n_errors++;
                $display("FAIL random_latency[%0d] op=%0d: got %0d", i, op, lat);
            end
        end
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            n_checks++;
            if (dbg_data !== m_regs[i]) begin
                n_errors++;
                $display("FAIL random_reg r%0d: got %h, want %h", i, dbg_data, m_regs[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [20:0] got, exp;
        issue(4'd8, 3'd3, 3'd0, 3'd0, 16'hA5A5, lat, got, exp);
        issue(4'd8, 3'd1, 3'd0, 3'd0, 16'h0123, lat, got, exp);
        @(negedge clk);
        cmd_op = 4'd9; cmd_rd = 3'd2; cmd_ra = 3'd1; cmd_rb = 3'd1; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({cmd_ready, busy, rsp_valid, rsp_data, rsp_flags, rsp_err} !== {1'b1, 1'b0, 1'b0, 21'h0}) begin
            n_errors++;
            $display("FAIL midreset_outputs: got rdy=%b busy=%b vld=%b %h/%b/%b, want 1 0 0 0000/0000/0",
                     cmd_ready, busy, rsp_valid, rsp_data, rsp_flags, rsp_err);
        end
        for (int i = 0; i < 8; i++) begin
            m_regs[i] = '0;
            dbg_addr = 3'(i);
            #1;
            n_checks++;
            if (dbg_data !== 16'h0) begin
                n_errors++;
                $display("FAIL midreset_reg r%0d: got %h, want 0000", i, dbg_data);
            end
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1 dbg_addr = 3'd2;
        #1;
        n_checks++;
        if ({cmd_ready, rsp_valid, dbg_data} !== {1'b1, 1'b0, 16'h0}) begin
            n_errors++;
            $display("FAIL midreset_after: got rdy=%b vld=%b r2=%h, want 1 0 0000", cmd_ready, rsp_valid, dbg_data);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_busy_drop();
        test_stall_illegal();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
